multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multi-cycle sequencing controller for the RV32I core. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB states. It consumes the control bits produced by `decoder_glue` and the branch comparator result, and drives the instruction/data memory handshakes plus the IR, PC and register-file write enables. It sits between the memories and the shared single ALU/regfile datapath, and is the only block allowed to commit architectural state.

## Interface
- `TIMEOUT`, default 255: maximum cycles a memory request may wait for ready before the controller faults.
- `CNT_W`, default 32: width of the retired-instruction counter.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `imem_valid`  out  1  instruction fetch request; held until accepted.
- `imem_ready`  in  1  instruction word available this cycle.
- `ir_we`  out  1  latch the fetched word into the IR.
- `regWrite`, `MemRead`, `MemWrite`, `BranchSig`, `Jump`, `JALR`  in  1 each  decoder control bits; valid from DECODE onward.
- `illegal`  in  1  decoder flags an opcode outside RV32I.
- `branch_taken`  in  1  comparator result; valid in EXEC.
- `dmem_valid`  out  1  data memory request.
- `dmem_we`  out  1  store qualifier for `dmem_valid`.
- `dmem_ready`  in  1  data access complete this cycle.
- `rf_we`  out  1  register-file write enable.
- `pc_we`  out  1  PC write enable.
- `pc_sel`  out  2  PC source: 0 selects PC+4; 1 selects PC+imm; 2 selects (rs1+imm)&~1.
- `state`  out  3  current state: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7.
- `halted`  out  1  sticky fault indicator.
- `fault_timeout`  out  1  the halt was caused by a memory timeout.
- `retire_cnt`  out  CNT_W  count of instructions completed through WB.

## Operation
- Register state: `state`, `pc_sel_q`, the wait counter `wcnt` (8 bits), `retire_cnt`, `fault_timeout`.
- All other outputs are decoded combinationally from `state` and the inputs, and are forced to 0 while `rst_n` is 0.
- FETCH:
  - `imem_valid` is 1.
  - When `imem_ready` is 1, `ir_we` is 1, `wcnt` clears, and the next state is DECODE.
  - Otherwise `wcnt` increments.
- DECODE (one cycle): the next state is HALT if any of these hold:
  - `illegal` is 1;
  - `MemRead` and `MemWrite` are both 1;
  - `BranchSig` and `Jump` are both 1.
  - Otherwise the next state is EXEC.
- EXEC (one cycle):
  - Registers `pc_sel_q` as follows: 2 if JALR; 1 if Jump, or if BranchSig and `branch_taken`; otherwise 0.
  - The next state is MEM if MemRead or MemWrite is 1; otherwise WB.
- MEM:
  - `dmem_valid` is 1 and `dmem_we` equals MemWrite.
  - When `dmem_ready` is 1, `wcnt` clears and the next state is WB; otherwise `wcnt` increments.
- WB (one cycle):
  - `rf_we` equals regWrite, `pc_we` is 1, and `pc_sel` equals `pc_sel_q`.
  - `retire_cnt` increments, wrapping modulo 2^CNT_W.
  - The next state is FETCH.
- `pc_sel` outputs 0 in every state other than WB.
- Timeout: in FETCH or MEM, if `wcnt` equals TIMEOUT and ready is still 0, the next state is HALT and `fault_timeout` is set.
- HALT:
  - All enables and requests are 0 and `halted` is 1.
  - The controller stays in HALT until `rst_n` goes low.
  - `retire_cnt` is frozen.

## Timing
- Reset: at a rising edge with `rst_n`=0, the controller sets `state`=FETCH and clears `wcnt`, `retire_cnt`, `pc_sel_q` and `fault_timeout`.
- Outputs while `rst_n`=0: all are 0, including `imem_valid`, `halted` and `state`.
- First request: `imem_valid` rises in the first cycle with `rst_n`=1.
- Latency from FETCH entry to next FETCH entry, with ready=1 on the first request cycle:
  - ALU, branch and jump instructions: 4 cycles.
  - Loads and stores: 5 cycles.
  - Each cycle that ready is held low adds 1 cycle.
- Handshake: a request is accepted on a cycle where valid and ready are both 1.
  - `imem_valid`/`dmem_valid` stay high, with `dmem_we` stable, until acceptance.
  - They drop in the cycle after acceptance.
  - Ready while valid is 0 is ignored.
- Reset mid-instruction: a reset during a MEM wait abandons the access. `dmem_valid` is 0 while `rst_n`=0, and no `rf_we`/`pc_we` pulse is emitted.
- Decoder inputs and `branch_taken` are sampled only in DECODE and EXEC; changes in other states have no effect.
- Exactly one `pc_we` pulse and at most one `rf_we` pulse are produced per retired instruction.

## Test plan
- Reset, then an ADD (regWrite=1) with `imem_ready`=1:
  - `state` sequence is 0,1,2,4,0.
  - `ir_we` pulses in cycle 1, `rf_we`/`pc_we` pulse in cycle 4 with `pc_sel`=0, and `retire_cnt`=1.
- LW with `dmem_ready` delayed 3 cycles:
  - `dmem_valid` is high for 4 cycles with `dmem_we`=0.
  - `rf_we` pulses once in WB, and the total is 8 cycles.
- SW, then BEQ taken, then JAL, then JALR:
  - SW: `dmem_we`=1 and `rf_we`=0.
  - BEQ: `pc_sel`=1 and `rf_we`=0.
  - JAL: `pc_sel`=1 and `rf_we`=1.
  - JALR: `pc_sel`=2.
  - `retire_cnt`=4 at the end.
- `illegal`=1 in DECODE: the next state is 7 with `halted`=1 and no `rf_we`/`pc_we`; it stays halted for 20 cycles until `rst_n` is low for 1 cycle, then returns to FETCH.
- `imem_ready` held at 0 with TIMEOUT=4: HALT with `fault_timeout`=1 after the 5th waiting cycle, and `retire_cnt` unchanged.
- `rst_n` low during a MEM wait: the next cycle shows `state`=0, `dmem_valid`=0 and `retire_cnt`=0, with no spurious writes.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// Instruction/data memory handshake bundle between the sequencing controller
// (master) and the memories (slave).
interface multicycle_ctrl_if;
  logic imem_valid;
  logic imem_ready;
  logic dmem_valid;
  logic dmem_we;
  logic dmem_ready;

  modport master (
    output imem_valid,
    output dmem_valid,
    output dmem_we,
    input  imem_ready,
    input  dmem_ready
  );

  modport slave (
    input  imem_valid,
    input  dmem_valid,
    input  dmem_we,
    output imem_ready,
    output dmem_ready
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencing controller: FETCH/DECODE/EXEC/MEM/WB with memory
// timeout fault, sticky HALT and retired-instruction counter.
module multicycle_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  multicycle_ctrl_if.master  mem_if,
  input  logic               i_reg_write,
  input  logic               i_mem_read,
  input  logic               i_mem_write,
  input  logic               i_branch_sig,
  input  logic               i_jump,
  input  logic               i_jalr,
  input  logic               i_illegal,
  input  logic               i_branch_taken,
  output logic               o_ir_we,
  output logic               o_rf_we,
  output logic               o_pc_we,
  output logic [1:0]         o_pc_sel,
  output logic [2:0]         o_state,
  output logic               o_halted,
  output logic               o_fault_timeout,
  output logic [CNT_W-1:0]   o_retire_cnt
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd7
  } state_e;

  localparam logic [7:0] TIMEOUT_W = 8'(TIMEOUT);

  state_e            r_state;
  logic [7:0]        r_wcnt;
  logic [1:0]        r_pc_sel_q;
  logic [CNT_W-1:0]  r_retire_cnt;
  logic              r_fault_timeout;
  logic              r_mem_we;
  logic              r_rf_we;
  logic              w_imem_valid;
  logic              w_dmem_valid;
  logic              w_dmem_we;

  // Sequencing FSM; store/writeback qualifiers are captured in EXEC so later
  // decoder activity cannot disturb an instruction already in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state         <= S_FETCH;
      r_wcnt          <= 8'd0;
      r_pc_sel_q      <= 2'd0;
      r_retire_cnt    <= '0;
      r_fault_timeout <= 1'b0;
      r_mem_we        <= 1'b0;
      r_rf_we         <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (mem_if.imem_ready) begin
            r_wcnt  <= 8'd0;
            r_state <= S_DECODE;
          end else if (r_wcnt == TIMEOUT_W) begin
            r_state         <= S_HALT;
            r_fault_timeout <= 1'b1;
          end else begin
            r_wcnt <= r_wcnt + 8'd1;
          end
        end
        S_DECODE: begin
          if (i_illegal || (i_mem_read && i_mem_write) || (i_branch_sig && i_jump)) begin
            r_state <= S_HALT;
          end else begin
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (i_jalr) begin
            r_pc_sel_q <= 2'd2;
          end else if (i_jump || (i_branch_sig && i_branch_taken)) begin
            r_pc_sel_q <= 2'd1;
          end else begin
            r_pc_sel_q <= 2'd0;
          end
          r_mem_we <= i_mem_write;
          r_rf_we  <= i_reg_write;
          r_state  <= (i_mem_read || i_mem_write) ? S_MEM : S_WB;
        end
        S_MEM: begin
          if (mem_if.dmem_ready) begin
            r_wcnt  <= 8'd0;
            r_state <= S_WB;
          end else if (r_wcnt == TIMEOUT_W) begin
            r_state         <= S_HALT;
            r_fault_timeout <= 1'b1;
          end else begin
            r_wcnt <= r_wcnt + 8'd1;
          end
        end
        S_WB: begin
          r_retire_cnt <= r_retire_cnt + CNT_W'(1);
          r_state      <= S_FETCH;
        end
        S_HALT: begin
          r_state <= S_HALT;
        end
        default: begin
          r_state <= S_HALT;
        end
      endcase
    end
  end

  // Output decode; everything reads as zero while reset is asserted.
  always_comb begin
    o_ir_we         = 1'b0;
    o_rf_we         = 1'b0;
    o_pc_we         = 1'b0;
    o_pc_sel        = 2'd0;
    o_state         = 3'd0;
    o_halted        = 1'b0;
    o_fault_timeout = 1'b0;
    o_retire_cnt    = '0;
    w_imem_valid    = 1'b0;
    w_dmem_valid    = 1'b0;
    w_dmem_we       = 1'b0;
    if (rst_n) begin
      o_state         = r_state;
      o_fault_timeout = r_fault_timeout;
      o_retire_cnt    = r_retire_cnt;
      case (r_state)
        S_FETCH: begin
          w_imem_valid = 1'b1;
          o_ir_we      = mem_if.imem_ready;
        end
        S_MEM: begin
          w_dmem_valid = 1'b1;
          w_dmem_we    = r_mem_we;
        end
        S_WB: begin
          o_rf_we  = r_rf_we;
          o_pc_we  = 1'b1;
          o_pc_sel = r_pc_sel_q;
        end
        S_HALT: begin
          o_halted = 1'b1;
        end
        default: begin
          o_halted = 1'b0;
        end
      endcase
    end else begin
      o_state = 3'd0;
    end
  end

  assign mem_if.imem_valid = w_imem_valid;
  assign mem_if.dmem_valid = w_dmem_valid;
  assign mem_if.dmem_we    = w_dmem_we;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: expected retire records are queued when an
// instruction is driven and checked when the controller pulses pc_we.
module tb_multicycle_ctrl;

  typedef struct {
    logic       rf_we;
    logic [1:0] pc_sel;
    logic       dmem_we;
    int         dmem_cycles;
    int         cycles;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_reg_write, i_mem_read, i_mem_write, i_branch_sig;
  logic        i_jump, i_jalr, i_illegal, i_branch_taken;
  logic        o_ir_we, o_rf_we, o_pc_we, o_halted, o_fault_timeout;
  logic [1:0]  o_pc_sel;
  logic [2:0]  o_state;
  logic [31:0] o_retire_cnt;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   exp_retire = 0;
  int   cyc = 0, n_ir = 0, n_dm = 0, n_stray = 0;
  logic [2:0] prev_st = 3'd7;

  multicycle_ctrl_if bus ();

  multicycle_ctrl #(.TIMEOUT(4), .CNT_W(32)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .mem_if          (bus.master),
    .i_reg_write     (i_reg_write),
    .i_mem_read      (i_mem_read),
    .i_mem_write     (i_mem_write),
    .i_branch_sig    (i_branch_sig),
    .i_jump          (i_jump),
    .i_jalr          (i_jalr),
    .i_illegal       (i_illegal),
    .i_branch_taken  (i_branch_taken),
    .o_ir_we         (o_ir_we),
    .o_rf_we         (o_rf_we),
    .o_pc_we         (o_pc_we),
    .o_pc_sel        (o_pc_sel),
    .o_state         (o_state),
    .o_halted        (o_halted),
    .o_fault_timeout (o_fault_timeout),
    .o_retire_cnt    (o_retire_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, expv, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bits(input logic rw, input logic mr, input logic mw, input logic br,
                          input logic jp, input logic jr, input logic il);
    i_reg_write = rw; i_mem_read = mr; i_mem_write = mw; i_branch_sig = br;
    i_jump = jp; i_jalr = jr; i_illegal = il;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_bits(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    i_branch_taken = 1'b0; bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0;
    tick();
    check_eq("rst_state", {29'd0, o_state}, 32'd0);
    check_eq("rst_imem_valid", {31'd0, bus.imem_valid}, 32'd0);
    check_eq("rst_dmem_valid", {31'd0, bus.dmem_valid}, 32'd0);
    check_eq("rst_halted", {31'd0, o_halted}, 32'd0);
    check_eq("rst_fault", {31'd0, o_fault_timeout}, 32'd0);
    check_eq("rst_retire", o_retire_cnt, 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    check_eq("first_req", {31'd0, bus.imem_valid}, 32'd1);
  endtask

  // kind: 0 ADD, 1 LW, 2 SW, 3 branch, 4 JAL, 5 JALR. Starts with the DUT in FETCH.
  task automatic run_instr(input int kind, input int idly, input int ddly, input logic taken);
    exp_t e;
    logic rw, mr, mw, br, jp, jr;
    rw = 1'b0; mr = 1'b0; mw = 1'b0; br = 1'b0; jp = 1'b0; jr = 1'b0;
    case (kind)
      1:       begin rw = 1'b1; mr = 1'b1; end
      2:       mw = 1'b1;
      3:       br = 1'b1;
      4:       begin rw = 1'b1; jp = 1'b1; end
      5:       begin rw = 1'b1; jr = 1'b1; end
      default: rw = 1'b1;
    endcase
    e.rf_we       = rw;
    e.pc_sel      = jr ? 2'd2 : ((jp || (br && taken)) ? 2'd1 : 2'd0);
    e.dmem_we     = mw;
    e.dmem_cycles = (mr || mw) ? ddly + 1 : 0;
    e.cycles      = 4 + idly + e.dmem_cycles;
    q.push_back(e);
    // garbage on the decoder lines during FETCH must be ignored
    set_bits(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    for (int d = 0; d < idly; d++) begin
      bus.imem_ready = 1'b0;
      tick();
    end
    bus.imem_ready = 1'b1;
    tick();
    check_eq("st_decode", {29'd0, o_state}, 32'd1);
    set_bits(rw, mr, mw, br, jp, jr, 1'b0);
    bus.dmem_ready = 1'b1;
    tick();
    check_eq("st_exec", {29'd0, o_state}, 32'd2);
    i_branch_taken = taken;
    tick();
    i_branch_taken = ~taken;
    if (mr || mw) begin
      check_eq("st_mem", {29'd0, o_state}, 32'd3);
      for (int d = 0; d < ddly; d++) begin
        bus.dmem_ready = 1'b0;
        tick();
      end
      bus.dmem_ready = 1'b1;
      tick();
    end
    check_eq("st_wb", {29'd0, o_state}, 32'd4);
    tick();
  endtask

  // Retire monitor: pops the scoreboard on every pc_we pulse.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_st = 3'd7; exp_retire = 0; cyc = 0; n_ir = 0; n_dm = 0; n_stray = 0;
    end else begin
      if (o_state == 3'd0 && prev_st != 3'd0) begin
        check_eq("retire_at_fetch", o_retire_cnt, 32'(exp_retire));
        cyc = 0; n_ir = 0; n_dm = 0; n_stray = 0;
      end
      cyc++;
      if (o_ir_we) n_ir++;
      if (bus.dmem_valid) begin
        n_dm++;
        if (q.size() > 0 && bus.dmem_we !== q[0].dmem_we) n_stray++;
      end
      if (o_state != 3'd4 && (o_pc_we || o_rf_we || o_pc_sel != 2'd0)) n_stray++;
      if (o_pc_we) begin
        if (q.size() == 0) begin
          check_eq("sb_underflow", 32'(q.size()), 32'd1);
        end else begin
          e = q.pop_front();
          check_eq("wb_rf_we", {31'd0, o_rf_we}, {31'd0, e.rf_we});
          check_eq("wb_pc_sel", {30'd0, o_pc_sel}, {30'd0, e.pc_sel});
          check_eq("latency", 32'(cyc), 32'(e.cycles));
          check_eq("dmem_cycles", 32'(n_dm), 32'(e.dmem_cycles));
          check_eq("ir_we_pulses", 32'(n_ir), 32'd1);
          check_eq("stray_or_dmem_we", 32'(n_stray), 32'd0);
          exp_retire++;
        end
      end
      prev_st = o_state;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    do_reset();
    run_instr(0, 0, 0, 1'b0);            // ADD
    run_instr(1, 0, 3, 1'b0);            // LW, dmem_ready 3 cycles late
    check_eq("retire_add_lw", o_retire_cnt, 32'd2);

    do_reset();
    run_instr(2, 1, 1, 1'b0);            // SW
    run_instr(3, 0, 0, 1'b1);            // BEQ taken
    run_instr(4, 2, 0, 1'b0);            // JAL
    run_instr(5, 0, 0, 1'b0);            // JALR
    check_eq("retire_four", o_retire_cnt, 32'd4);
    run_instr(3, 3, 0, 1'b0);            // branch not taken
    for (int i = 0; i < 12; i++) begin
      run_instr(int'($urandom_range(0, 5)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
    check_eq("retire_mix", o_retire_cnt, 32'd17);

    // decode-time faults: illegal, load+store, branch+jump
    for (int c = 0; c < 3; c++) begin
      do_reset();
      set_bits(1'b1, c == 1, c == 1, c == 2, c == 2, 1'b0, c == 0);
      bus.imem_ready = 1'b1;
      tick();
      check_eq("fault_decode", {29'd0, o_state}, 32'd1);
      tick();
      check_eq("halt_state", {29'd0, o_state}, 32'd7);
      check_eq("halt_flag", {31'd0, o_halted}, 32'd1);
      for (int k = 0; k < 20; k++) begin
        bus.imem_ready = 1'($urandom_range(0, 1));
        bus.dmem_ready = 1'($urandom_range(0, 1));
        tick();
        if (bus.imem_valid || bus.dmem_valid || o_ir_we) n_stray++;
      end
      check_eq("halt_sticky", {29'd0, o_state}, 32'd7);
      check_eq("halt_quiet", 32'(n_stray), 32'd0);
      check_eq("halt_no_timeout", {31'd0, o_fault_timeout}, 32'd0);
    end

    // fetch timeout after one retired instruction
    do_reset();
    run_instr(0, 0, 0, 1'b0);
    bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0;
    repeat (4) tick();
    check_eq("to_still_fetch", {29'd0, o_state}, 32'd0);
    tick();
    check_eq("to_halt", {29'd0, o_state}, 32'd7);
    check_eq("to_fault", {31'd0, o_fault_timeout}, 32'd1);
    check_eq("to_retire", o_retire_cnt, 32'd1);

    // data-side timeout
    do_reset();
    set_bits(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.imem_ready = 1'b1;
    repeat (3) tick();
    bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0;
    check_eq("mto_mem", {29'd0, o_state}, 32'd3);
    repeat (4) tick();
    check_eq("mto_wait", {29'd0, o_state}, 32'd3);
    tick();
    check_eq("mto_halt", {29'd0, o_state}, 32'd7);
    check_eq("mto_fault", {31'd0, o_fault_timeout}, 32'd1);

    // reset in the middle of a MEM wait
    do_reset();
    run_instr(0, 0, 0, 1'b0);
    set_bits(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.imem_ready = 1'b1;
    repeat (3) tick();
    bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0;
    tick();
    check_eq("abort_in_mem", {31'd0, bus.dmem_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("abort_dmem_low", {31'd0, bus.dmem_valid}, 32'd0);
    tick();
    check_eq("abort_state", {29'd0, o_state}, 32'd0);
    rst_n = 1'b1;
    #1;
    check_eq("abort_retire", o_retire_cnt, 32'd0);
    check_eq("abort_dmem", {31'd0, bus.dmem_valid}, 32'd0);
    check_eq("abort_refetch", {31'd0, bus.imem_valid}, 32'd1);
    set_bits(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_instr(0, 1, 0, 1'b0);
    check_eq("sb_drained", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
